pipe_decode_fwd: RTL and testbench
==================================

Name: pipe_decode_fwd

Overview:
- Next-generation decode/writeback stage for the pipelined Y86 core, with a parametrised datapath width and register count.
- Contains the register file: two combinational read ports and two synchronous write ports (W-stage dstE and dstM).
- Selects sources, forwards results from E/M/W, detects load-use hazards and owns the D/E pipeline register, including stall and bubble control.
- Sits between the fetch D-register and the execute stage.

Parameters:
- DATA_W, 64, datapath/register width in bits.
- NREG, 15, number of architectural registers (ids 0..NREG-1); id 4'hF is RNONE.
- RSP_ID, 4, register id used as the stack pointer.
- RSP_INIT, 0, reset value of the stack pointer register; all other registers reset to 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- D_stat  in  3  stat of the instruction in D
- D_icode, D_ifun, D_rA, D_rB  in  4 each  fields of the instruction in D
- D_valC, D_valP  in  DATA_W each  constant and next PC of the instruction in D
- e_dstE  in  4; e_valE  in  DATA_W  execute-stage result
- E_icode  in  4  icode currently in E (this block's own output, fed back); E_dstM  in  4
- e_cnd  in  1  branch outcome in E
- M_icode, M_dstE, M_dstM  in  4 each; M_valE, m_valM  in  DATA_W
- W_icode, W_dstE, W_dstM  in  4 each; W_valE, W_valM  in  DATA_W
- dbg_addr  in  4; dbg_data  out  DATA_W  combinational register-file peek
- d_srcA, d_srcB  out  4 each  combinational source ids
- d_valA, d_valB  out  DATA_W each  combinational forwarded operands
- d_stall  out  1  load-use stall request to F and D
- E_stat out 3; E_icode_o, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB out 4 each; E_valC, E_valA, E_valB out DATA_W  registered D/E outputs

Behaviour:
- d_srcA:
  - rA for icode 2, 4, 6, A.
  - RSP_ID for icode 9, B.
  - Else RNONE.
- d_srcB:
  - rB for icode 4, 5, 6.
  - RSP_ID for icode 8, 9, A, B.
  - Else RNONE.
- dstE:
  - rB for icode 2, 3, 6.
  - RSP_ID for icode 8, 9, A, B.
  - Else RNONE.
- dstM: rA for icode 5, B; else RNONE.
- Register read: returns regfile[id] for id < NREG; id >= NREG (including RNONE) reads 0.
- d_valA selection, in priority order:
  1. D_valP if icode 7 or 8.
  2. e_valE if srcA == e_dstE.
  3. m_valM if srcA == M_dstM.
  4. M_valE if srcA == M_dstE.
  5. W_valM if srcA == W_dstM.
  6. W_valE if srcA == W_dstE.
  7. Otherwise the register-file read.
- d_valB: same chain without step 1.
- A src of RNONE never matches any forwarding tag.
- Register write at posedge:
  - regfile[W_dstE] <= W_valE and regfile[W_dstM] <= W_valM.
  - Ids >= NREG are ignored.
  - If W_dstE == W_dstM, the M value wins.
- There is no read-during-write bypass inside the file; the W forwarding terms cover that case.
- d_stall = (E_icode is 5 or B) and E_dstM != RNONE and E_dstM is in {d_srcA, d_srcB}.
- E bubble = d_stall, or (E_icode == 7 and !e_cnd), or (any of D/E/M icode == 9).
- E register update at posedge:
  - On bubble, load the NOP image: icode 1, ifun 0, stat 1 (AOK), all ids RNONE, all values 0.
  - Otherwise capture the D-stage values: latency is 1 cycle.
- Reset (rst high at posedge) takes precedence over all other actions:
  - All registers are cleared and regfile[RSP_ID] is set to RSP_INIT.
  - The E register is loaded with the NOP image.
  - Register writes in that same cycle are dropped.
  - Mid-operation reset discards in-flight state.
- d_stall and the bubble are combinational; F and D hold externally while d_stall is high.

Test Plan:
- Reset with RSP_INIT=64'h200 -> dbg_addr=4 reads 64'h200; E_icode_o=1, E_stat=1, all E ids 4'hF.
- W_dstE=3, W_valE=7; next cycle D=OPq rA=3 rB=3 with no other hazards -> d_valA=d_valB=7 from the register file.
- e_dstE=2, e_valE=5, M_dstE=2, M_valE=9, D=rrmov rA=2 -> d_valA=5 (E priority over M).
- E_icode=5, E_dstM=1, D=OPq rA=1 -> d_stall=1 and the next E_icode_o=1 (bubble); E_dstM=4'hF -> no stall.
- E_icode=7, e_cnd=0 -> E register loaded with the NOP image next cycle; same case with e_cnd=1 -> D captured normally.
- W_dstE=W_dstM=5, W_valE=1, W_valM=2 -> regfile[5]=2; rst asserted in the same cycle -> regfile[5]=0.

Source files
------------

// File: rtl/pipe_decode_fwd_if.sv
// Decode-stage bus: D-register fields, E/M/W feedback tags and values, D/E register outputs.
// Latency: none, the interface only carries signals between bench/core and the stage.
// Backpressure: d_stall is the only flow-control signal; F and D hold while it is high.
interface pipe_decode_fwd_if #(
  parameter int DATA_W = 64
);
  // Instruction sitting in the fetch D-register
  logic [2:0]        D_stat;
  logic [3:0]        D_icode, D_ifun, D_rA, D_rB;
  logic [DATA_W-1:0] D_valC, D_valP;
  // Execute-stage feedback
  logic [3:0]        e_dstE;
  logic [DATA_W-1:0] e_valE;
  logic [3:0]        E_icode, E_dstM;
  logic              e_cnd;
  // Memory-stage feedback
  logic [3:0]        M_icode, M_dstE, M_dstM;
  logic [DATA_W-1:0] M_valE, m_valM;
  // Writeback-stage feedback, also drives the register-file write ports
  logic [3:0]        W_icode, W_dstE, W_dstM;
  logic [DATA_W-1:0] W_valE, W_valM;
  // Debug peek into the register file
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  // Combinational decode results
  logic [3:0]        d_srcA, d_srcB;
  logic [DATA_W-1:0] d_valA, d_valB;
  logic              d_stall;
  // Registered D/E outputs
  logic [2:0]        E_stat;
  logic [3:0]        E_icode_o, E_ifun, E_dstE, E_dstM_o, E_srcA, E_srcB;
  logic [DATA_W-1:0] E_valC, E_valA, E_valB;

  modport master (
    output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    output e_dstE, e_valE, E_icode, E_dstM, e_cnd,
    output M_icode, M_dstE, M_dstM, M_valE, m_valM,
    output W_icode, W_dstE, W_dstM, W_valE, W_valM,
    output dbg_addr,
    input  dbg_data, d_srcA, d_srcB, d_valA, d_valB, d_stall,
    input  E_stat, E_icode_o, E_ifun, E_dstE, E_dstM_o, E_srcA, E_srcB,
    input  E_valC, E_valA, E_valB
  );

  modport slave (
    input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
    input  e_dstE, e_valE, E_icode, E_dstM, e_cnd,
    input  M_icode, M_dstE, M_dstM, M_valE, m_valM,
    input  W_icode, W_dstE, W_dstM, W_valE, W_valM,
    input  dbg_addr,
    output dbg_data, d_srcA, d_srcB, d_valA, d_valB, d_stall,
    output E_stat, E_icode_o, E_ifun, E_dstE, E_dstM_o, E_srcA, E_srcB,
    output E_valC, E_valA, E_valB
  );
endinterface

// File: rtl/pipe_decode_fwd.sv
// Y86 decode/writeback stage: register file, source select, E/M/W forwarding, D/E register.
// Latency: operands combinational from D; D/E register captures one cycle later.
// Backpressure: load-use hazard raises d_stall (F/D hold) and bubbles E with a NOP.
module pipe_decode_fwd #(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter int                RSP_ID   = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input logic              clk,
  input logic              rst,
  pipe_decode_fwd_if.slave bus
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_ID);

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [DATA_W-1:0] val_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
  } de_t;

  localparam de_t NOP_IMG = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                              dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE,
                              val_c: '0, val_a: '0, val_b: '0};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  de_t               de_q, de_d;

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  logic              stall, bubble;

  // The W icode carries nothing this stage needs; writes are steered by the dst tags alone.
  logic unused_w_icode;
  assign unused_w_icode = ^bus.W_icode;

  // A RNONE source must never pick up a forwarded value, even if a tag is also RNONE
  function automatic logic hit(input logic [3:0] src, input logic [3:0] tag);
    return (src != RNONE) && (src == tag);
  endfunction

  // Source and destination id selection from the D icode
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = bus.D_rA;
      4'h9, 4'hB:             src_a = RSP;
      default:                src_a = RNONE;
    endcase
    case (bus.D_icode)
      4'h4, 4'h5, 4'h6:       src_b = bus.D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
      default:                src_b = RNONE;
    endcase
    case (bus.D_icode)
      4'h2, 4'h3, 4'h6:       dst_e = bus.D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
      default:                dst_e = RNONE;
    endcase
    if (bus.D_icode == 4'h5 || bus.D_icode == 4'hB) dst_m = bus.D_rA;
  end

  // Register-file reads; ids beyond the file (RNONE included) read as zero
  always_comb begin
    rf_a         = '0;
    rf_b         = '0;
    bus.dbg_data = '0;
    if (int'(src_a) < NREG)        rf_a         = regs_q[src_a];
    if (int'(src_b) < NREG)        rf_b         = regs_q[src_b];
    if (int'(bus.dbg_addr) < NREG) bus.dbg_data = regs_q[bus.dbg_addr];
  end

  // Forwarding: youngest producer wins, valP overrides srcA for call/jump
  always_comb begin
    if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) val_a = bus.D_valP;
    else if (hit(src_a, bus.e_dstE))                val_a = bus.e_valE;
    else if (hit(src_a, bus.M_dstM))                val_a = bus.m_valM;
    else if (hit(src_a, bus.M_dstE))                val_a = bus.M_valE;
    else if (hit(src_a, bus.W_dstM))                val_a = bus.W_valM;
    else if (hit(src_a, bus.W_dstE))                val_a = bus.W_valE;
    else                                            val_a = rf_a;

    if (hit(src_b, bus.e_dstE))      val_b = bus.e_valE;
    else if (hit(src_b, bus.M_dstM)) val_b = bus.m_valM;
    else if (hit(src_b, bus.M_dstE)) val_b = bus.M_valE;
    else if (hit(src_b, bus.W_dstM)) val_b = bus.W_valM;
    else if (hit(src_b, bus.W_dstE)) val_b = bus.W_valE;
    else                             val_b = rf_b;
  end

  // Load-use hazard and E bubble conditions
  always_comb begin
    stall  = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && (bus.E_dstM != RNONE) &&
             (bus.E_dstM == src_a || bus.E_dstM == src_b);
    bubble = stall || (bus.E_icode == 4'h7 && !bus.e_cnd) ||
             bus.D_icode == 4'h9 || bus.E_icode == 4'h9 || bus.M_icode == 4'h9;
  end

  // Next register-file contents from the two W write ports; the M port is applied last so it wins
  always_comb begin
    regs_d = regs_q;
    if (int'(bus.W_dstE) < NREG) regs_d[bus.W_dstE] = bus.W_valE;
    if (int'(bus.W_dstM) < NREG) regs_d[bus.W_dstM] = bus.W_valM;
  end

  // Next D/E image: NOP on bubble, otherwise the decoded D instruction
  always_comb begin
    de_d = NOP_IMG;
    if (!bubble) begin
      de_d = '{stat: bus.D_stat, icode: bus.D_icode, ifun: bus.D_ifun,
               dst_e: dst_e, dst_m: dst_m, src_a: src_a, src_b: src_b,
               val_c: bus.D_valC, val_a: val_a, val_b: val_b};
    end
  end

  // State update; reset drops same-cycle writes and reloads the NOP image
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
      de_q <= NOP_IMG;
    end else begin
      regs_q <= regs_d;
      de_q   <= de_d;
    end
  end

  assign bus.d_srcA    = src_a;
  assign bus.d_srcB    = src_b;
  assign bus.d_valA    = val_a;
  assign bus.d_valB    = val_b;
  assign bus.d_stall   = stall;
  assign bus.E_stat    = de_q.stat;
  assign bus.E_icode_o = de_q.icode;
  assign bus.E_ifun    = de_q.ifun;
  assign bus.E_dstE    = de_q.dst_e;
  assign bus.E_dstM_o  = de_q.dst_m;
  assign bus.E_srcA    = de_q.src_a;
  assign bus.E_srcB    = de_q.src_b;
  assign bus.E_valC    = de_q.val_c;
  assign bus.E_valA    = de_q.val_a;
  assign bus.E_valB    = de_q.val_b;
endmodule

// File: tb/tb_pipe_decode_fwd.sv
// Directed bench for pipe_decode_fwd: reset image, regfile, forwarding, stall and bubble.
// Latency: combinational outputs checked 1 time unit after input change, E outputs after a clock.
// Backpressure: d_stall driven by bench-controlled E_icode/E_dstM feedback.
module tb_pipe_decode_fwd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_decode_fwd_if #(.DATA_W(64)) bus ();

  pipe_decode_fwd #(
    .DATA_W(64), .NREG(15), .RSP_ID(4), .RSP_INIT(64'h200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.D_stat = 3'd1; bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
    bus.D_rA = 4'hF; bus.D_rB = 4'hF; bus.D_valC = '0; bus.D_valP = '0;
    bus.e_dstE = 4'hF; bus.e_valE = '0; bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd = 1'b1;
    bus.M_icode = 4'h1; bus.M_dstE = 4'hF; bus.M_dstM = 4'hF; bus.M_valE = '0; bus.m_valM = '0;
    bus.W_icode = 4'h1; bus.W_dstE = 4'hF; bus.W_dstM = 4'hF; bus.W_valE = '0; bus.W_valM = '0;
  endtask

  initial begin
    quiet();
    bus.dbg_addr = 4'h4;
    // Reset image
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    chk("rst_rsp", bus.dbg_data, 64'h200);
    bus.dbg_addr = 4'h3; #1;
    chk("rst_r3", bus.dbg_data, 64'h0);
    chk("rst_icode", bus.E_icode_o, 4'h1);
    chk("rst_stat", bus.E_stat, 3'd1);
    chk("rst_ids", {bus.E_dstE, bus.E_dstM_o, bus.E_srcA, bus.E_srcB}, 16'hFFFF);

    // Write r3=7, then OPq r3,r3 reads it from the file
    bus.W_dstE = 4'h3; bus.W_valE = 64'h7; tick();
    bus.W_dstE = 4'hF; bus.W_valE = '0;
    bus.D_icode = 4'h6; bus.D_ifun = 4'h2; bus.D_rA = 4'h3; bus.D_rB = 4'h3; bus.D_valC = 64'h11; #1;
    chk("opq_srcs", {bus.d_srcA, bus.d_srcB}, 8'h33);
    chk("opq_vala", bus.d_valA, 64'h7);
    chk("opq_valb", bus.d_valB, 64'h7);
    chk("opq_nostall", bus.d_stall, 1'b0);
    tick();
    chk("opq_E_icode", bus.E_icode_o, 4'h6);
    chk("opq_E_ifun", bus.E_ifun, 4'h2);
    chk("opq_E_ids", {bus.E_dstE, bus.E_dstM_o, bus.E_srcA, bus.E_srcB}, 16'h3F33);
    chk("opq_E_vals", {bus.E_valA, bus.E_valC}, {64'h7, 64'h11});

    // Forwarding priority on rrmovq r2 -> r7
    quiet();
    bus.D_icode = 4'h2; bus.D_rA = 4'h2; bus.D_rB = 4'h7;
    bus.e_dstE = 4'h2; bus.e_valE = 64'h5; bus.M_dstE = 4'h2; bus.M_valE = 64'h9; #1;
    chk("fwd_e_over_m", bus.d_valA, 64'h5);
    chk("rr_srcb_none", bus.d_srcB, 4'hF);
    bus.e_dstE = 4'hF; #1;
    chk("fwd_m_vale", bus.d_valA, 64'h9);
    bus.M_dstE = 4'hF; bus.W_dstM = 4'h2; bus.W_valM = 64'h33; #1;
    chk("fwd_w_valm", bus.d_valA, 64'h33);
    // RNONE source against RNONE tag must not forward
    bus.W_dstM = 4'hF; bus.e_dstE = 4'hF; bus.e_valE = 64'h55; #1;
    chk("rnone_nofwd", bus.d_valB, 64'h0);
    chk("rf_fallback", bus.d_valA, 64'h0);

    // call: valA = valP, srcB = rsp forwarded from W valE
    quiet();
    bus.D_icode = 4'h8; bus.D_valP = 64'h40; bus.e_dstE = 4'h4; bus.e_valE = 64'h99;
    bus.W_dstE = 4'h4; bus.W_valE = 64'h1F8; #1;
    chk("call_vala", bus.d_valA, 64'h40);
    chk("call_valb", bus.d_valB, 64'h99);
    bus.e_dstE = 4'hF; #1;
    chk("call_valb_w", bus.d_valB, 64'h1F8);

    // Load-use stall on srcA
    quiet();
    bus.D_icode = 4'h6; bus.D_rA = 4'h1; bus.D_rB = 4'h3;
    bus.E_icode = 4'h5; bus.E_dstM = 4'h1; #1;
    chk("lu_stall_a", bus.d_stall, 1'b1);
    tick();
    chk("lu_bubble", bus.E_icode_o, 4'h1);
    chk("lu_bubble_ids", {bus.E_dstE, bus.E_srcA}, 8'hFF);
    bus.E_dstM = 4'hF; #1;
    chk("lu_rnone", bus.d_stall, 1'b0);
    bus.D_rA = 4'h3; bus.D_rB = 4'h1; bus.E_icode = 4'hB; bus.E_dstM = 4'h1; #1;
    chk("lu_stall_b", bus.d_stall, 1'b1);
    bus.E_icode = 4'h6; #1;
    chk("nonload_nostall", bus.d_stall, 1'b0);

    // Mispredicted branch bubbles, taken branch captures
    quiet();
    bus.D_icode = 4'h6; bus.D_rA = 4'h3; bus.D_rB = 4'h3;
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0; tick();
    chk("mispred_nop", bus.E_icode_o, 4'h1);
    bus.e_cnd = 1'b1; tick();
    chk("taken_cap", bus.E_icode_o, 4'h6);
    chk("taken_vala", bus.E_valA, 64'h7);

    // ret in D: reads rsp, bubbles E
    quiet();
    bus.D_icode = 4'h9; #1;
    chk("ret_vala", bus.d_valA, 64'h200);
    tick();
    chk("ret_bubble", bus.E_icode_o, 4'h1);

    // Dual write to same register: M port wins
    quiet();
    bus.W_dstE = 4'h5; bus.W_dstM = 4'h5; bus.W_valE = 64'h1; bus.W_valM = 64'h2;
    bus.dbg_addr = 4'h5; tick();
    chk("dual_write", bus.dbg_data, 64'h2);
    // Reset in the same cycle as a write drops it and flushes E
    bus.W_valE = 64'h3; bus.W_valM = 64'h4;
    bus.D_icode = 4'h6; bus.D_rA = 4'h3; bus.D_rB = 4'h3; tick();
    chk("cap_before_rst", bus.E_icode_o, 4'h6);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rst_drops_write", bus.dbg_data, 64'h0);
    chk("rst_flush_E", bus.E_icode_o, 4'h1);
    bus.dbg_addr = 4'h4; #1;
    chk("rst_rsp_again", bus.dbg_data, 64'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
